overlay_feeder: RTL
===================

// Module: overlay_feeder
// PURPOSE
//  Transmit side of the overlay input interface. Buffers host samples in a FIFO.
//  On start, issues the stored instruction program on inst_in.
//  Then streams frames of PE_NUM samples on din_overlay and pulses load so the
//  overlay output PISO captures each completed frame.
// PARAMETERS
//  PE_NUM      `PE_NUM       samples per frame (one per PE)
//  DATA_WIDTH  `DATA_WIDTH   half-sample width; sample = 2*DATA_WIDTH (I/Q)
//  INST_WIDTH  `INST_WIDTH   instruction width
//  INST_DEPTH  16            instruction store entries (power of 2)
//  FIFO_DEPTH  16            sample FIFO entries (power of 2, >= PE_NUM)
//  LOAD_LAT    8             cycles from last frame sample to load pulse (>=1)
// PORTS
//  clk           in   1                    clock, rising edge
//  rst           in   1                    asynchronous, active-low reset
//  start         in   1                    pulse: begin program+stream (IDLE only)
//  inst_cnt      in   log2(INST_DEPTH)+1   instructions to issue, sampled on start
//  num_frames    in   16                   frames to send, sampled on start
//  inst_wr_v     in   1                    instruction store write strobe
//  inst_wr_addr  in   log2(INST_DEPTH)     write address
//  inst_wr_data  in   INST_WIDTH           write data
//  s_in_v        in   1                    host sample valid
//  s_in          in   2*DATA_WIDTH         host sample
//  s_in_rdy      out  1                    FIFO not full
//  inst_in_v     out  1                    instruction valid to overlay
//  inst_in       out  INST_WIDTH           instruction to overlay
//  din_overlay_v out  1                    sample valid to overlay
//  din_overlay   out  2*DATA_WIDTH         sample to overlay
//  load          out  1                    one-cycle PISO capture pulse
//  busy          out  1                    FSM not in IDLE
//  frame_done    out  1                    one-cycle pulse, coincident with load
// BEHAVIOUR
//  Reset: all outputs 0, except s_in_rdy = 1. FSM = IDLE, FIFO empty, counters 0.
//   Instruction store is not cleared.
//  FIFO: push on s_in_v & s_in_rdy; s_in_v while !s_in_rdy is dropped.
//   Push and pop in the same cycle keep the count unchanged.
//   s_in_rdy = (count != FIFO_DEPTH), so it is 0 when full. Pointers wrap modulo FIFO_DEPTH.
//  inst_wr_v: accepted only in IDLE; ignored while busy.
//  All data outputs are registered: an entry read or popped at cycle t appears at cycle t+1.
//  FSM:
//   IDLE : start=1 -> INST (latch inst_cnt, num_frames). start while busy is ignored.
//   INST : issue entries 0..inst_cnt-1 back-to-back, one per cycle, with inst_in_v=1.
//          inst_cnt=0 skips INST.
//          Exit to STREAM, or to IDLE when num_frames=0 (no load pulse in that case).
//   STREAM: pop when FIFO is non-empty and sample count < PE_NUM. Each pop gives one
//          din_overlay_v beat one cycle later. After PE_NUM pops -> WAIT.
//   WAIT : count LOAD_LAT cycles after the last din beat -> LOAD.
//   LOAD : load=1 and frame_done=1 for 1 cycle; frame counter +1.
//          Go to STREAM if frames remain, otherwise IDLE.
//  busy = (state != IDLE).
//  Host pushes continue in every state. A FIFO that stays empty stalls STREAM indefinitely.
//  rst asserted mid-frame: frame is abandoned; FIFO, counters and outputs cleared at once.
// CONFIGURATION
//  FEEDER_GAPLESS_EN defined:
//   STREAM starts popping only when count >= PE_NUM, then pops PE_NUM cycles back-to-back.
//   din_overlay_v is contiguous within a frame.
//  FEEDER_GAPLESS_EN undefined:
//   pop whenever non-empty; din_overlay_v may have gaps inside a frame.
// TESTING
//  1 Reset:
//   rst=0 mid-STREAM -> all outputs 0 and s_in_rdy=1 next edge; busy=0; FIFO empty.
//  2 Program+frame, PE_NUM=8, inst_cnt=3, num_frames=1, 8 samples preloaded,
//    start at cycle 0:
//   -> inst_in_v at cycles 1-3 (entries 0,1,2); din_overlay_v at cycles 4-11;
//      load at cycle 11+LOAD_LAT; then busy=0.
//  3 FIFO full: push 16 samples with no start -> s_in_rdy=0.
//   A 17th push is dropped; its data never appears on din_overlay.
//  4 Trickle feed, one sample every 3 cycles, num_frames=2:
//   without FEEDER_GAPLESS_EN -> gapped din beats;
//   with FEEDER_GAPLESS_EN -> no beats until 8 buffered, then 8 contiguous.
//   Both cases: 2 load pulses.
//  5 Edge cases: inst_cnt=0, num_frames=0 -> busy for 1 cycle, no inst/din/load.
//   start and inst_wr_v while busy -> ignored; program repeats unchanged.
//  6 Order check: 16 samples 0x0000_0001..0x0000_0010, num_frames=2
//   -> din_overlay emits them in push order, with load after sample 8 and after sample 16.

Source files
------------

// File: rtl/overlay_feeder_if.sv
// Overlay feeder bus: host-side control/sample inputs and overlay-side outputs.
// master = host/driver side, slave = feeder side.
interface overlay_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int INST_DEPTH = 16
);
    localparam int IAW = $clog2(INST_DEPTH);

    logic                    start;
    logic [IAW:0]            inst_cnt;
    logic [15:0]             num_frames;
    logic                    inst_wr_v;
    logic [IAW-1:0]          inst_wr_addr;
    logic [INST_WIDTH-1:0]   inst_wr_data;
    logic                    s_in_v;
    logic [2*DATA_WIDTH-1:0] s_in;
    logic                    s_in_rdy;
    logic                    inst_in_v;
    logic [INST_WIDTH-1:0]   inst_in;
    logic                    din_overlay_v;
    logic [2*DATA_WIDTH-1:0] din_overlay;
    logic                    load;
    logic                    busy;
    logic                    frame_done;

    modport master (
        output start, inst_cnt, num_frames, inst_wr_v, inst_wr_addr, inst_wr_data,
        output s_in_v, s_in,
        input  s_in_rdy, inst_in_v, inst_in, din_overlay_v, din_overlay,
        input  load, busy, frame_done
    );

    modport slave (
        input  start, inst_cnt, num_frames, inst_wr_v, inst_wr_addr, inst_wr_data,
        input  s_in_v, s_in,
        output s_in_rdy, inst_in_v, inst_in, din_overlay_v, din_overlay,
        output load, busy, frame_done
    );
endinterface

// File: rtl/overlay_feeder.sv
// overlay_feeder: transmit side of the overlay input. Buffers host samples in a
// FIFO, issues the stored instruction program on start, then streams frames of
// PE_NUM samples and pulses load/frame_done LOAD_LAT cycles after each frame.
// Optional: FEEDER_GAPLESS_EN -- hold a frame back until PE_NUM samples are
// buffered so din_overlay_v is contiguous within a frame.
module overlay_feeder #(
    parameter int PE_NUM     = 8,
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int INST_DEPTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LOAD_LAT   = 8
) (
    input logic             clk,
    input logic             rst,
    overlay_feeder_if.slave bus
);
    localparam int IAW = $clog2(INST_DEPTH);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = FAW + 1;
    localparam int PCW = $clog2(PE_NUM) + 1;
    localparam int WCW = $clog2(LOAD_LAT) + 1;
    localparam int SW  = 2 * DATA_WIDTH;

    localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);
    localparam logic [PCW-1:0] PE_CNT    = PCW'(PE_NUM);
    localparam logic [PCW-1:0] PE_LAST   = PCW'(PE_NUM - 1);
    localparam logic [WCW-1:0] LAT_LAST  = WCW'(LOAD_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_INST, S_STREAM, S_WAIT, S_LOAD} state_t;

    state_t                state_q;
    logic [INST_WIDTH-1:0] inst_mem [INST_DEPTH];
    logic [SW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]        count_q, count_d;
    logic [IAW:0]          cnt_q, idx_q;
    logic [15:0]           frames_q, fcnt_q;
    logic [PCW-1:0]        scnt_q;
    logic [WCW-1:0]        wcnt_q;
    logic                  inst_v_q, dout_v_q, load_q, fdone_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic [SW-1:0]         dout_q;
    logic                  push, pop;

    assign push = bus.s_in_v && (count_q != FIFO_FULL);

`ifdef FEEDER_GAPLESS_EN
    // A frame starts only once fully buffered; afterwards the data is guaranteed present.
    assign pop = (state_q == S_STREAM) && ((scnt_q != '0) || (count_q >= FCW'(PE_NUM)));
`else
    assign pop = (state_q == S_STREAM) && (count_q != '0) && (scnt_q < PE_CNT);
`endif

    // Instruction store: writable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (bus.inst_wr_v && state_q == S_IDLE)
            inst_mem[bus.inst_wr_addr] <= bus.inst_wr_data;
    end

    // Sample FIFO storage.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= bus.s_in;
    end

    // FIFO pointer/occupancy next state; pointers wrap naturally at power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q + FAW'(push);
        rd_ptr_d = rd_ptr_q + FAW'(pop);
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // FIFO pointer/occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Control FSM with registered outputs. Entry 0 is fetched on the start edge so
    // the program appears the cycle right after start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            frames_q <= '0;
            fcnt_q   <= '0;
            scnt_q   <= '0;
            wcnt_q   <= '0;
            inst_v_q <= 1'b0;
            inst_q   <= '0;
            dout_v_q <= 1'b0;
            dout_q   <= '0;
            load_q   <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            inst_v_q <= 1'b0;
            dout_v_q <= 1'b0;
            load_q   <= 1'b0;
            fdone_q  <= 1'b0;
            if (pop) begin
                dout_q   <= fifo_mem[rd_ptr_q];
                dout_v_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt_q    <= bus.inst_cnt;
                        frames_q <= bus.num_frames;
                        fcnt_q   <= '0;
                        idx_q    <= (IAW+1)'(1);
                        state_q  <= S_INST;
                        if (bus.inst_cnt != '0) begin
                            inst_q   <= inst_mem[0];
                            inst_v_q <= 1'b1;
                        end
                    end
                end
                S_INST: begin
                    if (idx_q < cnt_q) begin
                        inst_q   <= inst_mem[idx_q[IAW-1:0]];
                        inst_v_q <= 1'b1;
                        idx_q    <= idx_q + 1'b1;
                    end
                    if (idx_q + 1'b1 >= cnt_q) begin
                        scnt_q  <= '0;
                        state_q <= (frames_q == '0) ? S_IDLE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pop) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == PE_LAST) begin
                            scnt_q  <= '0;
                            wcnt_q  <= '0;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == LAT_LAST) begin
                        load_q  <= 1'b1;
                        fdone_q <= 1'b1;
                        state_q <= S_LOAD;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    fcnt_q  <= fcnt_q + 16'd1;
                    state_q <= (fcnt_q + 16'd1 == frames_q) ? S_IDLE : S_STREAM;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.s_in_rdy      = (count_q != FIFO_FULL);
    assign bus.inst_in_v     = inst_v_q;
    assign bus.inst_in       = inst_q;
    assign bus.din_overlay_v = dout_v_q;
    assign bus.din_overlay   = dout_q;
    assign bus.load          = load_q;
    assign bus.frame_done    = fdone_q;
    assign bus.busy          = (state_q != S_IDLE);
endmodule
